// File: rtl/vliw_issue_scoreboard.sv
// vliw_issue_scoreboard
// ---------------------
// Issue/interlock stage between fetch and the decode/execute datapath of the
// VLIW FP processor. One bundle of NCH sub-instructions is accepted per cycle.
// A per-register latency scoreboard freezes fetch on RAW/WAW hazards that
// exe-stage forwarding cannot cover. Same-bundle destination collisions are
// resolved with channel 0 at highest priority. BR_SLOTS bundles are discarded
// after a taken branch (flush).
//
// Ports:
//   clock        rising-edge clock
//   nReset       asynchronous active-low reset
//   in_valid     fetch presents a bundle
//   in_pc        bundle PC
//   src_a/src_b  per-channel source registers, channel c at [c*RN_W +: RN_W]
//   src_en       per channel: bit 2c = src_a used, bit 2c+1 = src_b used
//   dst          per-channel destination register
//   dst_lat      per-channel result latency, 0 = no register write
//   flush        taken branch resolved in the currently issued bundle
//   freeze       combinational; fetch holds the current bundle
//   issue_valid  registered; issue_* carry a live bundle
//   issue_en     registered per-channel enable after collision resolution
//   issue_pc     registered PC of the issued bundle (holds when nothing issues)
//   busy         bit r = scoreboard counter of register r is nonzero
module vliw_issue_scoreboard #(
   parameter int NCH      = 2,
   parameter int NREG     = 16,
   parameter int RN_W     = 4,
   parameter int LAT_W    = 3,
   parameter int PC_W     = 20,
   parameter int BR_SLOTS = 1
) (
   input  logic                  clock,
   input  logic                  nReset,
   input  logic                  in_valid,
   input  logic [PC_W-1:0]       in_pc,
   input  logic [NCH*RN_W-1:0]   src_a,
   input  logic [NCH*RN_W-1:0]   src_b,
   input  logic [NCH*2-1:0]      src_en,
   input  logic [NCH*RN_W-1:0]   dst,
   input  logic [NCH*LAT_W-1:0]  dst_lat,
   input  logic                  flush,
   output logic                  freeze,
   output logic                  issue_valid,
   output logic [NCH-1:0]        issue_en,
   output logic [PC_W-1:0]       issue_pc,
   output logic [NREG-1:0]       busy
);

   localparam int DC_W = $clog2(BR_SLOTS + 1);
   localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);

   // Per-channel views of the flattened bundle fields
   logic [NCH-1:0][RN_W-1:0]  ch_src_a;
   logic [NCH-1:0][RN_W-1:0]  ch_src_b;
   logic [NCH-1:0][RN_W-1:0]  ch_dst;
   logic [NCH-1:0][LAT_W-1:0] ch_lat;
   logic [NCH-1:0]            ch_rd_a;
   logic [NCH-1:0]            ch_rd_b;
   logic [NCH-1:0]            ch_wr;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         assign ch_src_a[gi] = src_a[gi*RN_W +: RN_W];
         assign ch_src_b[gi] = src_b[gi*RN_W +: RN_W];
         assign ch_dst[gi]   = dst[gi*RN_W +: RN_W];
         assign ch_lat[gi]   = dst_lat[gi*LAT_W +: LAT_W];
         assign ch_rd_a[gi]  = src_en[2*gi];
         assign ch_rd_b[gi]  = src_en[2*gi+1];
         assign ch_wr[gi]    = (dst_lat[gi*LAT_W +: LAT_W] != '0);
      end
   endgenerate

   // State
   logic [NREG-1:0][LAT_W-1:0] cnt_reg;
   logic [NREG-1:0][LAT_W-1:0] cnt_next;
   logic [DC_W-1:0]            discard_cnt_reg;
   logic                       issue_valid_reg;
   logic [NCH-1:0]             issue_en_reg;
   logic [PC_W-1:0]            issue_pc_reg;

   logic [NCH-1:0] survive;
   logic           hazard;
   logic           discard_zero;
   logic           issue;

   // A writing channel is dropped when any lower-numbered writing channel
   // targets the same register; non-writing channels always survive.
   always_comb begin
      survive = '1;
      for (int c = 1; c < NCH; c++) begin
         for (int j = 0; j < c; j++) begin
            if (ch_wr[j] && ch_wr[c] && (ch_dst[j] == ch_dst[c])) begin
               survive[c] = 1'b0;
            end
         end
      end
   end

   // cnt == 1 is covered by forwarding; anything above is a hazard. WAW
   // compares against the writer's own latency so writebacks stay in order.
   always_comb begin
      hazard = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         if (survive[c]) begin
            if (ch_rd_a[c] && (cnt_reg[ch_src_a[c]] > LAT_ONE)) hazard = 1'b1;
            if (ch_rd_b[c] && (cnt_reg[ch_src_b[c]] > LAT_ONE)) hazard = 1'b1;
            if (ch_wr[c] && (cnt_reg[ch_dst[c]] > ch_lat[c]))   hazard = 1'b1;
         end
      end
   end

   assign discard_zero = (discard_cnt_reg == '0);
   // Flush and pending discards both suppress the freeze: the bundle is
   // dropped anyway, so holding fetch would only waste a cycle.
   assign freeze = in_valid & discard_zero & ~flush & hazard;
   assign issue  = in_valid & discard_zero & ~flush & ~hazard;

   // Decrement every live counter; an issuing load overrides the decrement.
   // Surviving writers have distinct destinations, so loads never clash.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_next[r] = (cnt_reg[r] != '0) ? (cnt_reg[r] - LAT_ONE) : '0;
      end
      if (issue) begin
         for (int c = 0; c < NCH; c++) begin
            if (survive[c] && ch_wr[c]) begin
               cnt_next[ch_dst[c]] = ch_lat[c];
            end
         end
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // Reset value 1 drops the first bundle fetched after reset.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         discard_cnt_reg <= DC_W'(1);
      end else if (flush) begin
         discard_cnt_reg <= DC_W'(BR_SLOTS);
      end else if (in_valid && !discard_zero) begin
         discard_cnt_reg <= discard_cnt_reg - DC_W'(1);
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         issue_valid_reg <= 1'b0;
         issue_en_reg    <= '0;
         issue_pc_reg    <= '0;
      end else begin
         issue_valid_reg <= issue;
         issue_en_reg    <= issue ? survive : '0;
         if (issue) begin
            issue_pc_reg <= in_pc;
         end
      end
   end

   generate
      for (gi = 0; gi < NREG; gi++) begin : g_busy
         assign busy[gi] = (cnt_reg[gi] != '0);
      end
   endgenerate

   assign issue_valid = issue_valid_reg;
   assign issue_en    = issue_en_reg;
   assign issue_pc    = issue_pc_reg;

endmodule

// File: tb/tb_vliw_issue_scoreboard.sv
module tb_vliw_issue_scoreboard;

   localparam int NCH      = 2;
   localparam int NREG     = 16;
   localparam int RN_W     = 4;
   localparam int LAT_W    = 3;
   localparam int PC_W     = 20;
   localparam int BR_SLOTS = 2;

   logic                 clock;
   logic                 nReset;
   logic                 in_valid;
   logic [PC_W-1:0]      in_pc;
   logic [NCH*RN_W-1:0]  src_a;
   logic [NCH*RN_W-1:0]  src_b;
   logic [NCH*2-1:0]     src_en;
   logic [NCH*RN_W-1:0]  dst;
   logic [NCH*LAT_W-1:0] dst_lat;
   logic                 flush;
   logic                 freeze;
   logic                 issue_valid;
   logic [NCH-1:0]       issue_en;
   logic [PC_W-1:0]      issue_pc;
   logic [NREG-1:0]      busy;

   vliw_issue_scoreboard #(
      .NCH(NCH), .NREG(NREG), .RN_W(RN_W), .LAT_W(LAT_W), .PC_W(PC_W), .BR_SLOTS(BR_SLOTS)
   ) dut (
      .clock(clock), .nReset(nReset), .in_valid(in_valid), .in_pc(in_pc),
      .src_a(src_a), .src_b(src_b), .src_en(src_en), .dst(dst), .dst_lat(dst_lat),
      .flush(flush), .freeze(freeze), .issue_valid(issue_valid), .issue_en(issue_en),
      .issue_pc(issue_pc), .busy(busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        v;
      logic [19:0] pc;
      logic [7:0]  sa;
      logic [7:0]  sb;
      logic [3:0]  se;
      logic [7:0]  d;
      logic [5:0]  dl;
      logic        fl;
      logic        efz;
      logic        eiv;
      logic [1:0]  een;
      logic [15:0] ebusy;
   } vec_t;

   typedef struct {
      logic        iv;
      logic [1:0]  en;
      logic [19:0] pc;
      logic [15:0] busy;
   } exp_t;

   vec_t        vecs[$];
   exp_t        sbq[$];
   int          errors = 0;
   int          checks = 0;
   logic [19:0] exp_pc = '0;

   function automatic vec_t mk(input logic v, input logic [19:0] pc,
                               input logic [3:0] a0, input logic [3:0] b0, input logic [1:0] e0,
                               input logic [3:0] d0, input logic [2:0] l0,
                               input logic [3:0] a1, input logic [3:0] b1, input logic [1:0] e1,
                               input logic [3:0] d1, input logic [2:0] l1,
                               input logic fl, input logic efz, input logic eiv,
                               input logic [1:0] een, input logic [15:0] ebusy);
      vec_t t;
      t.v = v; t.pc = pc;
      t.sa = {a1, a0}; t.sb = {b1, b0}; t.se = {e1, e0};
      t.d = {d1, d0}; t.dl = {l1, l0};
      t.fl = fl; t.efz = efz; t.eiv = eiv; t.een = een; t.ebusy = ebusy;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      in_valid = t.v; in_pc = t.pc;
      src_a = t.sa; src_b = t.sb; src_en = t.se;
      dst = t.d; dst_lat = t.dl; flush = t.fl;
   endtask

   // Called just after a rising edge: drive, check freeze mid-cycle, then
   // compare the registered outputs after the next edge.
   task automatic apply(input int idx, input vec_t t);
      exp_t e;
      exp_t got;
      drive(t);
      @(negedge clock);
      chk($sformatf("freeze[%0d]", idx), 32'(freeze), 32'(t.efz));
      if (t.eiv) exp_pc = t.pc;
      e.iv = t.eiv; e.en = t.een; e.pc = exp_pc; e.busy = t.ebusy;
      sbq.push_back(e);
      @(posedge clock);
      #1;
      got = sbq.pop_front();
      chk($sformatf("issue_valid[%0d]", idx), 32'(issue_valid), 32'(got.iv));
      chk($sformatf("issue_en[%0d]", idx),    32'(issue_en),    32'(got.en));
      chk($sformatf("issue_pc[%0d]", idx),    32'(issue_pc),    32'(got.pc));
      chk($sformatf("busy[%0d]", idx),        32'(busy),        32'(got.busy));
      $display("vec %0d: pc=0x%0h v=%0b fl=%0b freeze=%0b -> iv=%0b en=%b ipc=0x%0h busy=0x%04h",
               idx, t.pc, t.v, t.fl, t.efz, issue_valid, issue_en, issue_pc, busy);
   endtask

   initial begin
      vec_t idle;
      idle = mk(0, 0, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,2'b00,16'h0);
      nReset = 1'b0;
      drive(idle);

      // post-reset drop, then first real issue
      vecs.push_back(mk(1,'h00, 0,0,0,1,2, 0,0,0,0,0, 0, 0,0,2'b00,16'h0000));
      vecs.push_back(mk(1,'h04, 0,0,0,0,0, 0,0,0,0,0, 0, 0,1,2'b11,16'h0000));
      // RAW: r3 lat 3, consumer frozen two cycles, busy[3] falls on its issue
      vecs.push_back(mk(1,'h08, 0,0,0,3,3, 0,0,0,0,0, 0, 0,1,2'b11,16'h0008));
      vecs.push_back(mk(1,'h0C, 3,0,1,0,0, 0,0,0,0,0, 0, 1,0,2'b00,16'h0008));
      vecs.push_back(mk(1,'h0C, 3,0,1,0,0, 0,0,0,0,0, 0, 1,0,2'b00,16'h0008));
      vecs.push_back(mk(1,'h0C, 3,0,1,0,0, 0,0,0,0,0, 0, 0,1,2'b11,16'h0000));
      // collision: ch0 r5 lat2 wins over ch1 r5 lat1, so r5 stays busy 2 cycles
      vecs.push_back(mk(1,'h10, 0,0,0,5,2, 0,0,0,5,1, 0, 0,1,2'b01,16'h0020));
      vecs.push_back(mk(1,'h14, 5,5,0,0,0, 0,0,0,0,0, 0, 0,1,2'b11,16'h0020));
      vecs.push_back(mk(1,'h18, 0,0,0,0,0, 0,0,0,0,0, 0, 0,1,2'b11,16'h0000));
      // latency 1: no freeze for the dependent bundle (ch1 src_b)
      vecs.push_back(mk(1,'h1C, 0,0,0,0,0, 0,0,0,2,1, 0, 0,1,2'b11,16'h0004));
      vecs.push_back(mk(1,'h20, 0,0,0,0,0, 0,2,2,0,0, 0, 0,1,2'b11,16'h0000));
      // WAW: r7 cnt 4, lat-1 writer waits until cnt 1
      vecs.push_back(mk(1,'h24, 0,0,0,7,4, 0,0,0,0,0, 0, 0,1,2'b11,16'h0080));
      vecs.push_back(mk(1,'h28, 0,0,0,0,0, 0,0,0,7,1, 0, 1,0,2'b00,16'h0080));
      vecs.push_back(mk(1,'h28, 0,0,0,0,0, 0,0,0,7,1, 0, 1,0,2'b00,16'h0080));
      vecs.push_back(mk(1,'h28, 0,0,0,0,0, 0,0,0,7,1, 0, 1,0,2'b00,16'h0080));
      vecs.push_back(mk(1,'h28, 0,0,0,0,0, 0,0,0,7,1, 0, 0,1,2'b11,16'h0080));
      vecs.push_back(mk(1,'h2C, 0,0,0,0,0, 0,0,0,0,0, 0, 0,1,2'b11,16'h0000));
      // dropped channel must not create a WAW hazard; r9 reloaded with 5
      vecs.push_back(mk(1,'h30, 0,0,0,9,3, 0,0,0,0,0, 0, 0,1,2'b11,16'h0200));
      vecs.push_back(mk(1,'h34, 0,0,0,9,5, 0,0,0,9,1, 0, 0,1,2'b01,16'h0200));
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(0,'h00, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,2'b00,16'h0200));
      vecs.push_back(mk(0,'h00, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,2'b00,16'h0000));
      // flush with continuous in_valid: two discarded bundles, no loads
      vecs.push_back(mk(1,'h38, 0,0,0,6,2, 0,0,0,0,0, 1, 0,0,2'b00,16'h0000));
      vecs.push_back(mk(1,'h3C, 0,0,0,6,2, 0,0,0,0,0, 0, 0,0,2'b00,16'h0000));
      vecs.push_back(mk(1,'h40, 0,0,0,6,2, 0,0,0,0,0, 0, 0,0,2'b00,16'h0000));
      vecs.push_back(mk(1,'h44, 0,0,0,6,2, 0,0,0,0,0, 0, 0,1,2'b11,16'h0040));
      // flush beats freeze; idle cycles do not consume discard slots
      vecs.push_back(mk(1,'h48, 6,0,1,0,0, 0,0,0,0,0, 1, 0,0,2'b00,16'h0040));
      vecs.push_back(mk(0,'h00, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,2'b00,16'h0000));
      vecs.push_back(mk(1,'h4C, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,2'b00,16'h0000));
      vecs.push_back(mk(1,'h50, 0,0,0,0,0, 0,0,0,0,0, 0, 0,0,2'b00,16'h0000));
      vecs.push_back(mk(1,'h54, 0,0,0,0,0, 0,0,0,0,0, 0, 0,1,2'b11,16'h0000));

      repeat (2) @(posedge clock);
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_issue_en",    32'(issue_en),    32'd0);
      chk("rst_issue_pc",    32'(issue_pc),    32'd0);
      chk("rst_busy",        32'(busy),        32'd0);
      chk("rst_freeze",      32'(freeze),      32'd0);
      nReset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // reset asserted while a bundle is frozen
      drive(mk(1,'h58, 0,0,0,3,7, 0,0,0,0,0, 0, 0,0,2'b00,16'h0));
      @(negedge clock);
      chk("rf_prod_freeze", 32'(freeze), 32'd0);
      @(posedge clock); #1;
      chk("rf_prod_iv",   32'(issue_valid), 32'd1);
      chk("rf_prod_pc",   32'(issue_pc),    32'h58);
      chk("rf_prod_busy", 32'(busy),        32'h0008);
      drive(mk(1,'h5C, 3,0,1,0,0, 0,0,0,0,0, 0, 0,0,2'b00,16'h0));
      @(negedge clock);
      chk("rf_cons_freeze", 32'(freeze), 32'd1);
      @(posedge clock); #1;
      chk("rf_cons_iv", 32'(issue_valid), 32'd0);
      #2;
      nReset = 1'b0;
      #1;
      chk("rf_rst_iv",     32'(issue_valid), 32'd0);
      chk("rf_rst_en",     32'(issue_en),    32'd0);
      chk("rf_rst_pc",     32'(issue_pc),    32'd0);
      chk("rf_rst_busy",   32'(busy),        32'd0);
      chk("rf_rst_freeze", 32'(freeze),      32'd0);
      $display("reset during freeze: iv=%0b pc=0x%0h busy=0x%04h freeze=%0b",
               issue_valid, issue_pc, busy, freeze);
      @(negedge clock);
      nReset = 1'b1;
      @(posedge clock); #1;
      chk("rf_drop_iv", 32'(issue_valid), 32'd0);
      @(negedge clock);
      chk("rf_retry_freeze", 32'(freeze), 32'd0);
      @(posedge clock); #1;
      chk("rf_retry_iv", 32'(issue_valid), 32'd1);
      chk("rf_retry_pc", 32'(issue_pc),    32'h5C);
      chk("rf_retry_en", 32'(issue_en),    32'h3);
      $display("re-presented bundle: iv=%0b pc=0x%0h en=%b", issue_valid, issue_pc, issue_en);
      drive(idle);
      chk("sbq_empty", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
